// File: rtl/fifo_reader_pkg.sv
// rtl/fifo_reader_pkg.sv - shared state encoding and word geometry for the FIFO byte reader
package fifo_reader_pkg;

  // Reader FSM states; encodings are fixed so other blocks can decode them
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    LOAD = 2'd2,
    SEND = 2'd3
  } state_e;

  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/fifo_byte_reader.sv
// rtl/fifo_byte_reader.sv - pops FIFO words and serialises them onto a valid/ready byte stream
module fifo_byte_reader
  import fifo_reader_pkg::*;
#(
  parameter int WORD_W    = 32,
  parameter int BYTE_W    = 8,
  parameter bit LSB_FIRST = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              EN,
  input  logic              fifoEmpty,
  input  logic [WORD_W-1:0] fifoData,
  output logic              fifoRD,
  output logic [BYTE_W-1:0] txData,
  output logic              txValid,
  input  logic              txReady,
  output logic              txLast,
  output logic              busy,
  output logic [CNT_W-1:0]  wordsDone
);

  localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

  state_e             state_q, state_d;
  logic [WORD_W-1:0]  shift_q, shift_d;
  logic [1:0]         byte_idx_q, byte_idx_d;
  logic [CNT_W-1:0]   words_done_q, words_done_d;

  // Next-state, shift register, byte index and word counter update
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    byte_idx_d   = byte_idx_q;
    words_done_d = words_done_q;
    case (state_q)
      IDLE: begin
        if (EN && !fifoEmpty) begin
          state_d = POP;
        end
      end
      POP: begin
        // FIFO dataOut becomes valid on the following cycle
        state_d = LOAD;
      end
      LOAD: begin
        shift_d    = fifoData;
        byte_idx_d = 2'd0;
        state_d    = SEND;
      end
      SEND: begin
        if (txReady) begin
          if (LSB_FIRST) begin
            shift_d = shift_q >> BYTE_W;
          end else begin
            shift_d = shift_q << BYTE_W;
          end
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == LAST_IDX) begin
            words_done_d = words_done_q + {{(CNT_W-1){1'b0}}, 1'b1};
            // EN only gates the start of the next pop, never the word in flight
            state_d = (EN && !fifoEmpty) ? POP : IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      byte_idx_q   <= 2'd0;
      words_done_q <= '0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      byte_idx_q   <= byte_idx_d;
      words_done_q <= words_done_d;
    end
  end

  // Moore-decoded outputs: nothing combinational from txReady reaches fifoRD
  assign fifoRD    = (state_q == POP);
  assign txValid   = (state_q == SEND);
  assign txLast    = (state_q == SEND) && (byte_idx_q == LAST_IDX);
  assign busy      = (state_q != IDLE);
  assign wordsDone = words_done_q;
  assign txData    = LSB_FIRST ? shift_q[BYTE_W-1:0] : shift_q[WORD_W-1 -: BYTE_W];

endmodule

// File: tb/tb_fifo_byte_reader.sv
// tb/tb_fifo_byte_reader.sv - scoreboard bench for fifo_byte_reader with behavioural FIFOs
module tb_fifo_byte_reader;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        EN = 1'b0;
  logic        txReady = 1'b1;

  logic        wr_en_a = 1'b0, wr_en_b = 1'b0;
  logic [31:0] wr_data_a = '0, wr_data_b = '0;
  logic [31:0] fifoData_a, fifoData_b;
  int          cnt_a, cnt_b;
  logic        fifoEmpty_a, fifoEmpty_b;
  logic        fifoRD_a, fifoRD_b;
  logic [7:0]  txData_a, txData_b;
  logic        txValid_a, txValid_b, txLast_a, txLast_b, busy_a, busy_b;
  logic [15:0] wordsDone_a, wordsDone_b;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          rd_cnt = 0;
  int          rd_cyc[$];
  logic [8:0]  exp_a[$];
  logic [8:0]  exp_b[$];

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  fifo_byte_reader #(.WORD_W(32), .BYTE_W(8), .LSB_FIRST(1'b1), .CNT_W(16)) dut_a (
    .Clk(Clk), .Rst(Rst), .EN(EN), .fifoEmpty(fifoEmpty_a), .fifoData(fifoData_a),
    .fifoRD(fifoRD_a), .txData(txData_a), .txValid(txValid_a), .txReady(txReady),
    .txLast(txLast_a), .busy(busy_a), .wordsDone(wordsDone_a));

  fifo_byte_reader #(.WORD_W(32), .BYTE_W(8), .LSB_FIRST(1'b0), .CNT_W(16)) dut_b (
    .Clk(Clk), .Rst(Rst), .EN(EN), .fifoEmpty(fifoEmpty_b), .fifoData(fifoData_b),
    .fifoRD(fifoRD_b), .txData(txData_b), .txValid(txValid_b), .txReady(txReady),
    .txLast(txLast_b), .busy(busy_b), .wordsDone(wordsDone_b));

  // Behavioural FIFOs: registered dataOut, EMPTY updated on the pop/write edge
  logic [31:0] fq_a[$];
  logic [31:0] fq_b[$];
  assign fifoEmpty_a = (cnt_a == 0);
  assign fifoEmpty_b = (cnt_b == 0);

  always @(posedge Clk) begin
    if (Rst) begin
      fq_a.delete(); fq_b.delete();
      cnt_a <= 0; cnt_b <= 0;
      fifoData_a <= '0; fifoData_b <= '0;
    end else begin
      if (fifoRD_a && fq_a.size() > 0) fifoData_a <= fq_a.pop_front();
      if (fifoRD_b && fq_b.size() > 0) fifoData_b <= fq_b.pop_front();
      if (wr_en_a) fq_a.push_back(wr_data_a);
      if (wr_en_b) fq_b.push_back(wr_data_b);
      cnt_a <= fq_a.size();
      cnt_b <= fq_b.size();
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic push_a(input logic [31:0] w);
    wr_en_a = 1'b1; wr_data_a = w;
    exp_a.push_back({1'b0, w[7:0]});
    exp_a.push_back({1'b0, w[15:8]});
    exp_a.push_back({1'b0, w[23:16]});
    exp_a.push_back({1'b1, w[31:24]});
    step();
    wr_en_a = 1'b0;
  endtask

  task automatic push_b(input logic [31:0] w);
    wr_en_b = 1'b1; wr_data_b = w;
    exp_b.push_back({1'b0, w[31:24]});
    exp_b.push_back({1'b0, w[23:16]});
    exp_b.push_back({1'b0, w[15:8]});
    exp_b.push_back({1'b1, w[7:0]});
    step();
    wr_en_b = 1'b0;
  endtask

  task automatic wait_idle(input bit sel_b, input string name);
    bit done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge Clk);
      if (!sel_b) done = !busy_a && fifoEmpty_a && (exp_a.size() == 0);
      else        done = !busy_b && fifoEmpty_b && (exp_b.size() == 0);
    end
    check(name, {63'd0, done}, 64'd1);
    step();
  endtask

  task automatic wait_valid_a(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge Clk);
      seen = txValid_a;
    end
    check(name, {63'd0, seen}, 64'd1);
  endtask

  // Monitor: pops the scoreboard on every byte handshake and checks hold-while-stalled
  initial begin
    logic       prev_stall = 1'b0;
    logic [8:0] prev_byte = '0;
    logic [8:0] e;
    forever begin
      @(negedge Clk);
      if (fifoRD_a) begin
        rd_cnt++;
        rd_cyc.push_back(cyc);
        check("rd_while_empty_a", {63'd0, fifoEmpty_a}, 64'd0);
      end
      if (fifoRD_b) check("rd_while_empty_b", {63'd0, fifoEmpty_b}, 64'd0);
      if (prev_stall && !Rst) begin
        check("hold_valid_a", {63'd0, txValid_a}, 64'd1);
        check("hold_byte_a", {55'd0, txLast_a, txData_a}, {55'd0, prev_byte});
      end
      prev_stall = txValid_a && !txReady && !Rst;
      prev_byte  = {txLast_a, txData_a};
      if (txValid_a && txReady && !Rst) begin
        if (exp_a.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL byte_a: unexpected byte 0x%0h last=%0b (cycle %0d)", txData_a, txLast_a, cyc);
        end else begin
          e = exp_a.pop_front();
          check("byte_a", {55'd0, txLast_a, txData_a}, {55'd0, e});
        end
      end
      if (txValid_b && txReady && !Rst) begin
        if (exp_b.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL byte_b: unexpected byte 0x%0h last=%0b (cycle %0d)", txData_b, txLast_b, cyc);
        end else begin
          e = exp_b.pop_front();
          check("byte_b", {55'd0, txLast_b, txData_b}, {55'd0, e});
        end
      end
    end
  end

  // Directed stimulus
  initial begin
    int c0, rd0;
    bit got;
    repeat (3) step();
    Rst = 1'b0;
    @(negedge Clk);
    check("rst_txValid", {63'd0, txValid_a}, 64'd0);
    check("rst_busy", {63'd0, busy_a}, 64'd0);
    check("rst_fifoRD", {63'd0, fifoRD_a}, 64'd0);
    check("rst_txLast", {63'd0, txLast_a}, 64'd0);
    check("rst_txData", {56'd0, txData_a}, 64'd0);
    check("rst_wordsDone", {48'd0, wordsDone_a}, 64'd0);
    step();

    // Single word, with first-byte latency
    EN = 1'b1;
    push_a(32'hA1B2C3D4);
    @(negedge Clk);
    check("lat_idle_rd", {63'd0, fifoRD_a}, 64'd0);
    step(); @(negedge Clk);
    check("lat_pop_rd", {63'd0, fifoRD_a}, 64'd1);
    step(); @(negedge Clk);
    check("lat_load_valid", {63'd0, txValid_a}, 64'd0);
    check("lat_load_busy", {63'd0, busy_a}, 64'd1);
    step(); @(negedge Clk);
    check("lat_send_valid", {63'd0, txValid_a}, 64'd1);
    check("lat_first_byte", {56'd0, txData_a}, 64'hD4);
    wait_idle(1'b0, "single_idle");
    check("single_words", {48'd0, wordsDone_a}, 64'd1);
    check("single_rd_cnt", rd_cnt, 64'd1);

    // EN low with data present, then back-to-back drain
    EN = 1'b0;
    push_a(32'h03020100);
    push_a(32'h07060504);
    push_a(32'h0B0A0908);
    repeat (4) step();
    @(negedge Clk);
    check("en0_rd_cnt", rd_cnt, 64'd1);
    check("en0_busy", {63'd0, busy_a}, 64'd0);
    step();
    rd_cyc.delete();
    EN = 1'b1;
    wait_idle(1'b0, "b2b_idle");
    check("b2b_pops", rd_cyc.size(), 64'd3);
    if (rd_cyc.size() == 3) begin
      check("b2b_gap0", rd_cyc[1] - rd_cyc[0], 64'd6);
      check("b2b_gap1", rd_cyc[2] - rd_cyc[1], 64'd6);
    end
    check("b2b_empty", {63'd0, fifoEmpty_a}, 64'd1);
    check("b2b_words", {48'd0, wordsDone_a}, 64'd4);

    // Backpressure: txReady low for 5 cycles on byte 2
    push_a(32'hDEADBEEF);
    wait_valid_a("bp_valid");
    c0 = cyc;
    step();
    txReady = 1'b0;
    repeat (5) step();
    txReady = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge Clk);
      got = (wordsDone_a == 16'd5);
    end
    check("bp_done", {63'd0, got}, 64'd1);
    check("bp_latency", cyc - c0, 64'd9);
    wait_idle(1'b0, "bp_idle");

    // Drop EN mid-word: word finishes, no new pop until EN returns
    push_a(32'h44332211);
    push_a(32'h88776655);
    wait_valid_a("en_mid_valid");
    step();
    EN = 1'b0;
    rd0 = rd_cnt;
    repeat (12) step();
    @(negedge Clk);
    check("en_mid_rd", rd_cnt, rd0);
    check("en_mid_busy", {63'd0, busy_a}, 64'd0);
    check("en_mid_words", {48'd0, wordsDone_a}, 64'd6);
    step();
    EN = 1'b1;
    step(); @(negedge Clk);
    check("en_resume_rd", {63'd0, fifoRD_a}, 64'd1);
    wait_idle(1'b0, "en_resume_idle");
    check("en_resume_words", {48'd0, wordsDone_a}, 64'd7);

    // Reset after the first byte of a word
    push_a(32'h11223344);
    while (exp_a.size() > 1) void'(exp_a.pop_back());
    wait_valid_a("rst_mid_valid");
    step();
    Rst = 1'b1; txReady = 1'b0;
    step();
    @(negedge Clk);
    check("rst_mid_valid0", {63'd0, txValid_a}, 64'd0);
    check("rst_mid_busy0", {63'd0, busy_a}, 64'd0);
    check("rst_mid_words0", {48'd0, wordsDone_a}, 64'd0);
    step();
    Rst = 1'b0; txReady = 1'b1;
    repeat (8) step();
    check("rst_mid_sb_empty", exp_a.size(), 64'd0);
    check("rst_mid_busy", {63'd0, busy_a}, 64'd0);

    // MSB-first instance
    push_b(32'hA1B2C3D4);
    wait_idle(1'b1, "msb_idle");
    check("msb_words", {48'd0, wordsDone_b}, 64'd1);
    check("sb_a_drained", exp_a.size(), 64'd0);
    check("sb_b_drained", exp_b.size(), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
